// File: rtl/link_reset_sequencer.sv
// link_reset_sequencer: serial-link bring-up sequencer driving a paired watchdog_timer.
module link_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 7,
  parameter int RETRY_W       = 3
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               wd_expired,
  input  logic               rx_locked,
  output logic               wd_kick,
  output logic               link_rst,
  output logic               link_up,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               fail
);
  localparam int CMAX = RST_CYCLES > STABLE_CYCLES ? RST_CYCLES : STABLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [2:0] {RST, WAIT, STAB, UP, FAIL} state_t;
  state_t             state, nxt;
  logic [CW-1:0]      cnt, nxt_cnt;
  logic [RETRY_W-1:0] nxt_retry;
  logic               att_fail;
  always_comb begin
    nxt       = state;
    nxt_cnt   = cnt;
    nxt_retry = retry_cnt;
    att_fail  = 1'b0;
    case (state)
      RST: begin
        nxt     = cnt == CW'(RST_CYCLES - 1) ? WAIT : RST;
        nxt_cnt = cnt == CW'(RST_CYCLES - 1) ? '0 : cnt + CW'(1);
      end
      WAIT: begin
        nxt      = rx_locked ? STAB : WAIT;
        nxt_cnt  = '0;
        att_fail = !rx_locked && wd_expired;
      end
      STAB: begin
        att_fail = !rx_locked;
        nxt      = cnt == CW'(STABLE_CYCLES - 1) ? UP : STAB;
        nxt_cnt  = cnt + CW'(1);
      end
      UP: begin
        nxt     = rx_locked ? UP : RST;
        nxt_cnt = '0;
      end
      default: ;
    endcase
    // a failed attempt overrides whatever the phase logic chose
    if (att_fail) begin
      nxt       = retry_cnt == RETRY_W'(MAX_RETRIES - 1) ? FAIL : RST;
      nxt_cnt   = '0;
      nxt_retry = retry_cnt + RETRY_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= RST;
      cnt       <= '0;
      retry_cnt <= '0;
      link_rst  <= 1'b1;
      wd_kick   <= 1'b1;
      link_up   <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= nxt_cnt;
      retry_cnt <= nxt_retry;
      link_rst  <= nxt == RST || nxt == FAIL;
      wd_kick   <= nxt != WAIT;
      link_up   <= nxt == UP;
      fail      <= nxt == FAIL;
    end
  end
endmodule
